// File: rtl/client_arb_mux.sv
// client_arb_mux: per-channel beat FIFOs feeding a packet-atomic round-robin
// arbiter that drives a single AXI-Stream master.
module client_arb_mux #(
  parameter int DATAW      = 512,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DESTW      = 5,
  parameter int IDW        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*DATAW-1:0] client_tdata,
  input  logic [NUM_CH*DESTW-1:0] client_tdest,
  input  logic [NUM_CH-1:0]       client_tlast,
  input  logic [NUM_CH-1:0]       client_valid,
  output logic [NUM_CH-1:0]       client_ready,
  input  logic                    axis_client_interface_tready,
  output logic                    axis_client_interface_tvalid,
  output logic                    axis_client_interface_tlast,
  output logic [DESTW-1:0]        axis_client_interface_tdest,
  output logic [IDW-1:0]          axis_client_interface_tid,
  output logic [DATAW/8-1:0]      axis_client_interface_tstrb,
  output logic [DATAW/8-1:0]      axis_client_interface_tkeep,
  output logic                    axis_client_interface_tuser,
  output logic [DATAW-1:0]        axis_client_interface_tdata
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(NUM_CH);
  localparam int EW = DATAW + DESTW + 1;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [GW-1:0]     grant_r, grant_s;
  logic [GW-1:0]     last_grant_r, last_grant_s;
  logic [GW-1:0]     pick_s;
  logic              any_s;
  logic [NUM_CH-1:0] push_s, pop_s, nempty_s;
  logic [NUM_CH*EW-1:0] head_flat_s;
  logic [EW-1:0]     head_s;
  logic              head_valid_s;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [EW-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] cnt_r;

    assign nempty_s[c]     = (cnt_r != {CW{1'b0}});
    assign client_ready[c] = (cnt_r != CW'(FIFO_DEPTH)) & rst;
    assign push_s[c]       = client_valid[c] & client_ready[c];
    assign pop_s[c]        = (state_r == STREAM) && (grant_r == GW'(c)) &&
                             nempty_s[c] && axis_client_interface_tready;
    assign head_flat_s[c*EW +: EW] = mem_r[rd_ptr_r];

    // Beat storage: entry layout is {tdata, tdest, tlast}
    always_ff @(posedge clk) begin
      if (push_s[c]) begin
        mem_r[wr_ptr_r] <= {client_tdata[c*DATAW +: DATAW],
                            client_tdest[c*DESTW +: DESTW], client_tlast[c]};
      end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        cnt_r    <= {CW{1'b0}};
      end else begin
        if (push_s[c]) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
        if (pop_s[c])  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
        case ({push_s[c], pop_s[c]})
          2'b10:   cnt_r <= cnt_r + CW'(1'b1);
          2'b01:   cnt_r <= cnt_r - CW'(1'b1);
          default: cnt_r <= cnt_r;
        endcase
      end
    end
  end

  assign any_s        = |nempty_s;
  assign head_s       = head_flat_s[int'(grant_r)*EW +: EW];
  assign head_valid_s = nempty_s[grant_r];

  // Round-robin pick: walk downward so the nearest channel after last_grant wins
  always_comb begin : p_pick
    int idx;
    logic [GW-1:0] cand;
    pick_s = {GW{1'b0}};
    idx    = 0;
    cand   = {GW{1'b0}};
    for (int i = NUM_CH; i >= 1; i--) begin
      idx    = int'(last_grant_r) + i;
      idx    = (idx >= NUM_CH) ? idx - NUM_CH : idx;
      cand   = GW'(idx);
      pick_s = nempty_s[cand] ? cand : pick_s;
    end
  end

  // Arbiter next-state: a grant is held until its tlast beat leaves
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_s      = STREAM;
          grant_s      = pick_s;
          last_grant_s = pick_s;
        end else begin
          state_s      = IDLE;
        end
      end
      STREAM: begin
        if ((|pop_s) && head_s[0]) begin
          state_s = IDLE;
        end else begin
          state_s = STREAM;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Arbiter state register; last_grant starts at the top so channel 0 wins first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      grant_r      <= {GW{1'b0}};
      last_grant_r <= GW'(NUM_CH - 1);
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
    end
  end

  // AXIS master drive: payload follows the granted FIFO head, zeros when idle
  always_comb begin
    axis_client_interface_tvalid = 1'b0;
    axis_client_interface_tlast  = 1'b0;
    axis_client_interface_tdest  = {DESTW{1'b0}};
    axis_client_interface_tid    = {IDW{1'b0}};
    axis_client_interface_tdata  = {DATAW{1'b0}};
    axis_client_interface_tstrb  = {(DATAW/8){1'b1}};
    axis_client_interface_tkeep  = {(DATAW/8){1'b1}};
    axis_client_interface_tuser  = 1'b0;
    if (state_r == STREAM) begin
      axis_client_interface_tvalid = head_valid_s;
      axis_client_interface_tlast  = head_s[0];
      axis_client_interface_tdest  = head_s[DESTW:1];
      axis_client_interface_tid    = IDW'(grant_r);
      axis_client_interface_tdata  = head_s[EW-1 -: DATAW];
    end else begin
      axis_client_interface_tvalid = 1'b0;
    end
  end
endmodule

// File: tb/tb_client_arb_mux.sv
// Directed self-checking bench for client_arb_mux (4 channels, 32-bit beats).
module tb_client_arb_mux;
  localparam int DW  = 32;
  localparam int NC  = 4;
  localparam int FD  = 8;
  localparam int DSW = 5;
  localparam int IW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC*DW-1:0] client_tdata;
  logic [NC*DSW-1:0] client_tdest;
  logic [NC-1:0]    client_tlast;
  logic [NC-1:0]    client_valid;
  logic [NC-1:0]    client_ready;
  logic             tready;
  logic             tvalid, tlast, tuser;
  logic [DSW-1:0]   tdest;
  logic [IW-1:0]    tid;
  logic [DW/8-1:0]  tstrb, tkeep;
  logic [DW-1:0]    tdata;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic tog_en = 1'b0;

  typedef struct {
    int             cyc;
    logic [IW-1:0]  tid;
    logic [DSW-1:0] tdest;
    logic           tlast;
    logic [DW-1:0]  tdata;
  } beat_t;
  beat_t out_q[$];

  logic           prev_stall = 1'b0;
  logic [DW-1:0]  sv_data;
  logic [DSW-1:0] sv_dest;
  logic [IW-1:0]  sv_tid;
  logic           sv_last;

  client_arb_mux #(.DATAW(DW), .NUM_CH(NC), .FIFO_DEPTH(FD), .DESTW(DSW), .IDW(IW)) dut (
    .clk(clk), .rst(rst),
    .client_tdata(client_tdata), .client_tdest(client_tdest),
    .client_tlast(client_tlast), .client_valid(client_valid),
    .client_ready(client_ready),
    .axis_client_interface_tready(tready),
    .axis_client_interface_tvalid(tvalid),
    .axis_client_interface_tlast(tlast),
    .axis_client_interface_tdest(tdest),
    .axis_client_interface_tid(tid),
    .axis_client_interface_tstrb(tstrb),
    .axis_client_interface_tkeep(tkeep),
    .axis_client_interface_tuser(tuser),
    .axis_client_interface_tdata(tdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepted-beat log plus stall-stability and tdest checks
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", 64'(tvalid), 64'(1));
        check("stall_tdata", 64'(tdata), 64'(sv_data));
        check("stall_tdest", 64'(tdest), 64'(sv_dest));
        check("stall_tid", 64'(tid), 64'(sv_tid));
        check("stall_tlast", 64'(tlast), 64'(sv_last));
      end
      if (tvalid && tready) begin
        out_q.push_back('{cyc, tid, tdest, tlast, tdata});
        check("tdest_map", 64'(tdest), 64'(tid) + 64'd10);
      end
      prev_stall <= tvalid && !tready;
      sv_data    <= tdata;
      sv_dest    <= tdest;
      sv_tid     <= tid;
      sv_last    <= tlast;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
    if (tog_en) tready = ~tready;
  endtask

  task automatic push_beat(input int c, input logic [DW-1:0] d, input logic l);
    int n;
    client_tdata[c*DW +: DW] = d;
    client_tlast[c]  = l;
    client_valid[c]  = 1'b1;
    n = 0;
    while (!client_ready[c] && n < 200) begin
      sync();
      n++;
    end
    check("push_ready", 64'(client_ready[c]), 64'(1));
    sync();
    client_valid[c] = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int k;
    k = 0;
    while (out_q.size() < n && k < 500) begin
      sync();
      k++;
    end
    check(tag, 64'(out_q.size()), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    tready = 1'b0;
    client_valid = '0;
    client_tlast = '0;
    client_tdata = '0;
    for (int c = 0; c < NC; c++) client_tdest[c*DSW +: DSW] = DSW'(c + 10);

    // reset state
    #2;
    check("rst_ready", 64'(client_ready), 64'(0));
    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_tstrb", 64'(tstrb), 64'(4'hF));
    check("rst_tkeep", 64'(tkeep), 64'(4'hF));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(client_ready), 64'(4'hF));
    check("idle_tvalid", 64'(tvalid), 64'(0));
    check("idle_tdata", 64'(tdata), 64'(0));
    check("idle_tid", 64'(tid), 64'(0));
    check("idle_tdest", 64'(tdest), 64'(0));
    check("idle_tlast", 64'(tlast), 64'(0));
    check("idle_tuser", 64'(tuser), 64'(0));

    // minimum latency and stall stability
    sync();
    push_beat(0, 32'h000000A1, 1'b1);
    @(negedge clk);
    check("lat_idle_after_push", 64'(tvalid), 64'(0));
    sync();
    @(negedge clk);
    check("lat_tvalid", 64'(tvalid), 64'(1));
    check("lat_tdata", 64'(tdata), 64'(32'hA1));
    check("lat_tid", 64'(tid), 64'(0));
    check("lat_tlast", 64'(tlast), 64'(1));
    check("lat_tstrb", 64'(tstrb), 64'(4'hF));
    sync();
    sync();
    tready = 1'b1;
    sync();
    tready = 1'b0;
    @(negedge clk);
    check("lat_back_to_idle", 64'(tvalid), 64'(0));
    sync();
    check("lat_count", 64'(out_q.size()), 64'(1));
    check("lat_data", 64'(out_q[0].tdata), 64'(32'hA1));
    out_q.delete();

    // single channel, 20 beats, tready toggling every cycle
    tog_en = 1'b1;
    for (int i = 1; i <= 20; i++) push_beat(0, DW'(i), (i == 20));
    wait_beats(20, "r029_count");
    repeat (4) sync();
    tog_en = 1'b0;
    tready = 1'b0;
    check("r029_no_dup", 64'(out_q.size()), 64'(20));
    for (int i = 0; i < 20; i++) begin
      check("r029_data", 64'(out_q[i].tdata), 64'(i + 1));
      check("r029_tid", 64'(out_q[i].tid), 64'(0));
      check("r029_tlast", 64'(out_q[i].tlast), 64'(i == 19));
    end
    out_q.delete();

    // four channels, one 3-beat packet each, round-robin order
    sync();
    for (int c = 0; c < NC; c++)
      for (int b = 0; b < 3; b++) push_beat(c, DW'(c*256 + b), (b == 2));
    tready = 1'b1;
    wait_beats(12, "r030_count");
    repeat (3) sync();
    tready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check("r030_tid", 64'(out_q[k].tid), 64'(k / 3));
      check("r030_data", 64'(out_q[k].tdata), 64'((k / 3)*256 + (k % 3)));
      check("r030_tlast", 64'(out_q[k].tlast), 64'((k % 3) == 2));
      if (k > 0)
        check("r030_spacing", 64'(out_q[k].cyc - out_q[k-1].cyc), 64'(((k % 3) == 0) ? 2 : 1));
    end
    out_q.delete();

    // packet atomicity across an underrun on channel 1
    sync();
    push_beat(1, 32'h11, 1'b0);
    push_beat(1, 32'h12, 1'b0);
    for (int b = 0; b < 3; b++) push_beat(2, DW'(32'h21 + b), (b == 2));
    tready = 1'b1;
    repeat (5) sync();
    @(negedge clk);
    check("r031_gap_tvalid", 64'(tvalid), 64'(0));
    sync();
    check("r031_held_count", 64'(out_q.size()), 64'(2));
    push_beat(1, 32'h13, 1'b1);
    wait_beats(6, "r031_count");
    repeat (3) sync();
    tready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("r031_tid", 64'(out_q[k].tid), 64'((k < 3) ? 1 : 2));
      check("r031_data", 64'(out_q[k].tdata), 64'((k < 3) ? (32'h11 + k) : (32'h21 + k - 3)));
    end
    check("r031_tvalid_gap", 64'((out_q[2].cyc - out_q[1].cyc) > 1), 64'(1));
    check("r031_ch2_after_last", 64'(out_q[3].cyc - out_q[2].cyc), 64'(2));
    out_q.delete();

    // fill channel 0 with tready low, then free one slot
    sync();
    for (int i = 0; i < FD; i++) begin
      push_beat(0, DW'(32'h80 + i), (i == FD - 1));
      @(negedge clk);
      check("r032_ready_fill", 64'(client_ready[0]), 64'(i < FD - 1));
    end
    sync();
    tready = 1'b1;
    sync();
    tready = 1'b0;
    @(negedge clk);
    check("r032_ready_back", 64'(client_ready[0]), 64'(1));
    check("r032_ready_ch1", 64'(client_ready[1]), 64'(1));
    tready = 1'b1;
    wait_beats(FD, "r032_count");
    tready = 1'b0;
    for (int i = 0; i < FD; i++)
      check("r032_data", 64'(out_q[i].tdata), 64'(32'h80 + i));
    repeat (2) sync();
    out_q.delete();

    // reset during beat 2 of a 4-beat packet on channel 3
    for (int b = 0; b < 4; b++) push_beat(3, DW'(32'h31 + b), (b == 3));
    sync();
    tready = 1'b1;
    sync();
    tready = 1'b0;
    @(negedge clk);
    check("r033_beat2_valid", 64'(tvalid), 64'(1));
    check("r033_beat2_data", 64'(tdata), 64'(32'h32));
    #1 rst = 1'b0;
    #1;
    check("r033_rst_tvalid", 64'(tvalid), 64'(0));
    check("r033_rst_ready", 64'(client_ready), 64'(0));
    sync();
    sync();
    rst = 1'b1;
    tready = 1'b1;
    repeat (4) sync();
    @(negedge clk);
    check("r033_no_partial_tvalid", 64'(tvalid), 64'(0));
    sync();
    check("r033_no_partial_count", 64'(out_q.size()), 64'(1));
    check("r033_beat1", 64'(out_q[0].tdata), 64'(32'h31));
    client_tdata[0 +: DW]  = 32'h44;
    client_tdata[DW +: DW] = 32'h55;
    client_tlast[1:0] = 2'b11;
    client_valid[1:0] = 2'b11;
    sync();
    client_valid = '0;
    wait_beats(3, "r033_count");
    check("r033_first_new_data", 64'(out_q[1].tdata), 64'(32'h44));
    check("r033_first_new_tid", 64'(out_q[1].tid), 64'(0));
    check("r033_second_new_data", 64'(out_q[2].tdata), 64'(32'h55));
    check("r033_second_new_tid", 64'(out_q[2].tid), 64'(1));
    tready = 1'b0;
    repeat (2) sync();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/client_arb_mux.md
CLIENT_ARB_MUX -- requirements
Module: client_arb_mux

Interface
Parameters
- REQ-001: The block SHALL have parameter DATAW, default 512, giving the payload width per beat in bits.
- REQ-002: The block SHALL have parameter NUM_CH, default 4, giving the number of client channels (range 2..16).
- REQ-003: The block SHALL have parameter FIFO_DEPTH, default 8, giving the per-channel buffer depth in beats (power of two, at least 2).
- REQ-004: The block SHALL have parameter DESTW, default 5, giving the width of tdest.
- REQ-005: The block SHALL have parameter IDW, default 4, giving the width of tid (IDW at least clog2(NUM_CH)).

Ports
- REQ-006: The block SHALL have port clk, input, width 1: the single clock; all logic is rising-edge.
- REQ-007: The block SHALL have port rst, input, width 1: reset, asynchronous and active-low.
- REQ-008: The block SHALL have port client_tdata, input, width NUM_CH*DATAW: channel c occupies bits [c*DATAW +: DATAW].
- REQ-009: The block SHALL have port client_tdest, input, width NUM_CH*DESTW: per-beat destination for each channel.
- REQ-010: The block SHALL have port client_tlast, input, width NUM_CH: per-channel end-of-packet flag.
- REQ-011: The block SHALL have port client_valid, input, width NUM_CH: per-channel beat valid.
- REQ-012: The block SHALL have port client_ready, output, width NUM_CH: per-channel ready.
- REQ-013: The block SHALL have port axis_client_interface_tready, input, width 1: downstream ready.
- REQ-014: The block SHALL have output ports axis_client_interface_tvalid (1), tlast (1), tdest (DESTW), tid (IDW), tstrb (DATAW/8), tkeep (DATAW/8), tuser (1) and tdata (DATAW), forming the AXI-Stream master.

Function
- REQ-015: Each channel SHALL own a FIFO of FIFO_DEPTH entries holding {tdata, tdest, tlast}; a push occurs on a rising edge where client_valid[c] and client_ready[c] are both high.
- REQ-016: client_ready[c] SHALL equal (FIFO c not full) AND rst high, evaluated combinationally from the registered occupancy count.
- REQ-017: A simultaneous push and pop on the same FIFO SHALL leave its count unchanged; push SHALL be impossible when full, and pop SHALL be impossible when empty.
- REQ-018: The arbiter FSM SHALL have exactly two states: IDLE and STREAM.
- REQ-019: In IDLE, if any FIFO is non-empty, the FSM SHALL grant the first non-empty channel searching round-robin from last_grant+1 (mod NUM_CH), register grant and last_grant, and enter STREAM on the next edge; otherwise it SHALL stay in IDLE.
- REQ-020: In STREAM, axis_client_interface_tvalid SHALL equal (granted FIFO non-empty); tdata, tdest and tlast SHALL come from the granted FIFO head; tid SHALL equal the grant index zero-extended; tstrb and tkeep SHALL be all ones; tuser SHALL be 0.
- REQ-021: A pop SHALL occur only on an edge where tvalid and tready are both high.
- REQ-022: While tvalid is high and tready is low, all output payload signals SHALL remain stable.
- REQ-023: Grants SHALL be packet-atomic: if the granted FIFO goes empty mid-packet, tvalid SHALL drop, the grant SHALL be held, and no other channel SHALL be served.
- REQ-024: The edge that pops a beat with tlast=1 SHALL return the FSM to IDLE, so there is exactly one idle cycle between packets.
- REQ-025: Minimum latency SHALL be 1 cycle from the push edge of a beat into an idle, empty block to tvalid high; the grant is taken on the edge after the push.
- REQ-026: In IDLE, all AXIS outputs SHALL be 0, except tstrb and tkeep, which SHALL be all ones.

Reset
- REQ-027: While rst is low, the block SHALL asynchronously clear all FIFO pointers and counts, set state to IDLE, grant to 0 and last_grant to NUM_CH-1 (so channel 0 wins first), and drive client_ready to all zeros and tvalid to 0.
- REQ-028: A reset asserted mid-packet SHALL discard all buffered beats; no partial packet SHALL be emitted after reset is released.

Verification
- REQ-029: Single channel 0, beats 1..20 with tlast on 20, and tready toggling 1/0 every cycle -> exactly 20 beats emitted in order, tid=0, tlast only on beat 20, no duplicates or losses.
- REQ-030: Channels 0..3 each hold one 3-beat packet, tready=1 -> packets emitted in order ch0, ch1, ch2, ch3 with tid 0..3 and one idle cycle between packets.
- REQ-031: Channel 1 sends beats 1-2, stalls 5 cycles, then sends beat 3 with tlast, while channel 2 has a full packet pending -> ch1's 3 beats are emitted contiguously with a tvalid gap, and ch2 starts only after ch1's tlast.
- REQ-032: tready=0 and channel 0 pushed FIFO_DEPTH beats -> client_ready[0]=0 after the 8th push; then tready=1 for one cycle -> client_ready[0]=1 on the next cycle.
- REQ-033: rst pulsed low during beat 2 of a 4-beat packet -> tvalid=0 immediately and client_ready=0 during reset; after release, the first output is the first newly pushed beat.
- REQ-034: Check the tdest pass-through with client_tdest[c]=c+10 -> output tdest equals 10+tid for every beat.
